// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-back entry type used by the
// write-back queue and its testbenches.
package regfile_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wbq_fwd_match.sv
// Newest-first search of the pending write-back entries for one read address.
// Walks from head (oldest) towards tail so the last hit found is the newest.
module regfile_wbq_fwd_match
  import regfile_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = RF_ADDR_W,
  parameter  int DATA_W = RF_DATA_W,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] addrs [DEPTH],
  input  logic [DATA_W-1:0] datas [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PTR_W-1:0]  head,
  input  logic [ADDR_W-1:0] rd,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  always_comb begin : search
    logic [PTR_W-1:0] idx;
    // NOTE: every output and local gets a default before the loop so no path
    // through this block leaves a value unassigned and infers a latch.
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && (addrs[idx] == rd) && (rd != '0)) begin
        hit  = 1'b1;
        data = datas[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue in front of the register file write port, with
// optional read-side forwarding of pending data (macro REGFILE_WBQ_FORWARD_EN).
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_wr,
  input  logic [DATA_W-1:0] in_data,
  output logic              regwrite,
  output logic [ADDR_W-1:0] wr,
  output logic [DATA_W-1:0] writedata,
  input  logic              rf_ready,
  input  logic [ADDR_W-1:0] rd1,
  input  logic [ADDR_W-1:0] rd2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W:0]    count;
  logic              full, empty, push, pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Register 0 is hardwired, so its writes complete the handshake but are dropped.
  assign push = in_valid && !full && (in_wr != '0);
  assign pop  = !empty && rf_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the entry storage is not reset; an entry is only ever read while
  // count marks it valid, so its power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_addr[tail] <= in_wr;
      mem_data[tail] <= in_data;
    end
  end

  assign in_ready  = !full;
  assign regwrite  = !empty;
  assign wr        = empty ? '0 : mem_addr[head];
  assign writedata = empty ? '0 : mem_data[head];

`ifdef REGFILE_WBQ_FORWARD_EN
  logic [DEPTH-1:0] valid;

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin : valid_mask
    logic [PTR_W-1:0] age;
    valid = '0;
    age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age      = PTR_W'(i) - head;
      valid[i] = ({1'b0, age} < count);
    end
  end

  regfile_wbq_fwd_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_match1 (
    .addrs(mem_addr),
    .datas(mem_data),
    .valid(valid),
    .head (head),
    .rd   (rd1),
    .hit  (fwd1_hit),
    .data (fwd1_data)
  );

  regfile_wbq_fwd_match #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_match2 (
    .addrs(mem_addr),
    .datas(mem_data),
    .valid(valid),
    .head (head),
    .rd   (rd2),
    .hit  (fwd2_hit),
    .data (fwd2_data)
  );
`else
  logic unused_rd;
  assign unused_rd = ^{rd1, rd2};

  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-side front end for the 32×32 register file. Collects register write requests from the datapath through a valid/ready handshake and buffers them in a small in-order queue. Drains at most one entry per cycle into the register file write port (`regwrite`/`wr`/`writedata`). Optionally forwards pending, not-yet-written data to the register file read side so readers never see stale values.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; empties the queue this cycle.
- in_valid  in  1  write request valid.
- in_ready  out  1  queue can accept; equals !full.
- in_wr  in  ADDR_W  destination register.
- in_data  in  DATA_W  write data.
- regwrite  out  1  register file write strobe; equals !empty.
- wr  out  ADDR_W  head entry address; 0 when empty.
- writedata  out  DATA_W  head entry data; 0 when empty.
- rf_ready  in  1  register file accepts the write this cycle.
- rd1, rd2  in  ADDR_W  read addresses presented to the register file.
- fwd1_hit, fwd2_hit  out  1  a pending entry targets rd1/rd2.
- fwd1_data, fwd2_data  out  DATA_W  newest pending data for rd1/rd2; 0 on miss.

## Operation
- Circular FIFO with head and tail pointers (log2 DEPTH bits, wrap modulo DEPTH) and a count (log2 DEPTH + 1 bits).
- Push: in_valid && in_ready enqueues {in_wr, in_data} at tail.
- Push with in_wr == 0: handshake completes (in_ready honoured) but nothing is enqueued, because register 0 is never written.
- Pop: regwrite && rf_ready advances head.
- Simultaneous push and pop: count unchanged; both pointers advance. Allowed only when not full. in_ready is never asserted when full, so there is no pass-through.
- Multiple pending entries to the same register are all kept and drained in order. No coalescing.
- Forwarding: combinational search of valid entries, newest-first priority. rdN == 0 is always a miss. An entry being pushed this cycle is not searched. An entry being popped this cycle still hits.
- flush: count and pointers cleared. Any push or pop in the same cycle is ignored. Outputs go idle the next cycle.

## Timing
- Reset values: in_ready 1, regwrite 0, wr 0, writedata 0, all fwd outputs 0, count 0, pointers 0.
- Reset asserted mid-operation discards all entries immediately (asynchronous).
- Push-to-regwrite latency is 1 cycle when the queue is empty.
- Outputs hold steady while rf_ready is low.
- in_ready, regwrite, wr and writedata are derived only from registered state. No combinational path from in_valid or rf_ready to any output.
- Forwarding outputs are combinational from rd1/rd2 and queue state.

## Configuration
- REGFILE_WBQ_FORWARD_EN defined: the forwarding comparators and muxes are built.
- Not defined: fwd1_hit, fwd2_hit, fwd1_data and fwd2_data are tied to 0. Ports are kept so the interface does not change, and no comparators are built.

## Structure
- Shared package regfile_pkg:
  - constants RF_ADDR_W = 5, RF_DATA_W = 32, RF_NUM_REGS = 32;
  - typedef wb_entry_t, a struct {addr, data}.
- One sub-module, regfile_wbq_fwd_match: newest-first priority search over the entry array, valid mask and head pointer for one read address. It is instantiated twice.

## Test plan
- Reset, then push {wr=3, data=0xDEADBEEF} with rf_ready=1 -> next cycle regwrite=1, wr=3, writedata=0xDEADBEEF for 1 cycle, then regwrite=0.
- rf_ready=0, push 4 entries (regs 1..4) -> in_ready=0 after the 4th. Then rf_ready=1 -> writes drain in order 1,2,3,4, and in_ready rises the cycle after the first pop.
- Push {5, 0x11}, then {5, 0x22}, with rf_ready=0 and rd1=5 -> fwd1_hit=1, fwd1_data=0x22. Drain one -> still 0x22. Drain both -> fwd1_hit=0.
- Push {0, 0xFFFF} -> handshake accepted, regwrite stays 0. rd2=0 -> fwd2_hit=0.
- 3 entries pending, assert flush together with in_valid -> count 0 next cycle, regwrite=0, no entry from that push.
- Drop rst_n mid-drain -> regwrite, wr and writedata are 0 immediately. After release, in_ready=1 and the queue is empty.
